// File: rtl/core_idu_shift_dec_pkg.sv
// Shared decode constants, the decoded-entry record and the shift decode
// function for the IDU shift-class decode stage.
package core_idu_shift_dec_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   localparam int OP_TYPE_W = 6;

   localparam logic [OP_TYPE_W-1:0] OP_TYPE_NONE = 6'd0;
   localparam logic [OP_TYPE_W-1:0] OP_TYPE_SLL  = 6'd1;
   localparam logic [OP_TYPE_W-1:0] OP_TYPE_SLLI = 6'd2;
   localparam logic [OP_TYPE_W-1:0] OP_TYPE_SRL  = 6'd3;
   localparam logic [OP_TYPE_W-1:0] OP_TYPE_SRLI = 6'd4;
   localparam logic [OP_TYPE_W-1:0] OP_TYPE_SRA  = 6'd5;
   localparam logic [OP_TYPE_W-1:0] OP_TYPE_SRAI = 6'd6;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;
   localparam logic [6:0] F7_LOG = 7'b0000000;
   localparam logic [6:0] F7_ARI = 7'b0100000;

   typedef struct packed {
      logic [31:0]          pc;
      logic [31:0]          inst;
      logic [OP_TYPE_W-1:0] op_type;
      logic [4:0]           rs1_idx;
      logic [4:0]           rs2_idx;
      logic [4:0]           rd_idx;
      logic [31:0]          imme;
      logic                 rd_we;
      logic                 is_shift;
      logic                 illegal;
   } dec_pkt_t;

   localparam int DEC_PKT_W = $bits(dec_pkt_t);

   // Pure combinational decode of one raw word into a buffer entry.
   function automatic dec_pkt_t shift_decode(input logic [31:0] inst, input logic [31:0] pc);
      dec_pkt_t             p;
      logic                 is_imm;
      logic                 is_reg;
      logic                 shift_grp;
      logic                 legal;
      logic [OP_TYPE_W-1:0] op;
      logic [6:0]           f7;
      logic [2:0]           f3;

      is_imm    = (inst[6:0] == OPC_OPIMM);
      is_reg    = (inst[6:0] == OPC_OP);
      f3        = inst[14:12];
      f7        = inst[31:25];
      shift_grp = (is_imm | is_reg) & ((f3 == F3_SLL) | (f3 == F3_SRX));
      legal     = 1'b0;
      op        = OP_TYPE_NONE;

      if (shift_grp) begin
         if (f3 == F3_SLL) begin
            legal = (f7 == F7_LOG);
            op    = is_imm ? OP_TYPE_SLLI : OP_TYPE_SLL;
         end else if (f7 == F7_LOG) begin
            legal = 1'b1;
            op    = is_imm ? OP_TYPE_SRLI : OP_TYPE_SRL;
         end else if (f7 == F7_ARI) begin
            legal = 1'b1;
            op    = is_imm ? OP_TYPE_SRAI : OP_TYPE_SRA;
         end
      end

      p.pc       = pc;
      p.inst     = inst;
      p.rs1_idx  = inst[19:15];
      p.rd_idx   = inst[11:7];
      // Immediate forms carry the shift amount in the rs2 field; report no rs2.
      p.rs2_idx  = is_imm ? 5'd0 : inst[24:20];
      p.imme     = is_imm ? {{20{inst[31]}}, inst[31:20]} : 32'd0;
      p.op_type  = legal ? op : OP_TYPE_NONE;
      p.is_shift = legal;
      p.illegal  = shift_grp & ~legal;
      p.rd_we    = legal & (inst[11:7] != 5'd0);
      return p;
   endfunction

endpackage

// File: rtl/core_idu_shift_dec_if.sv
// Bundle of the IFU-side and EXU-side handshakes of the shift decode stage.
// master = environment (IFU producer / EXU consumer), slave = the decode stage.
interface core_idu_shift_dec_if
   import core_idu_shift_dec_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic                 inst_valid;
   logic                 inst_ready;
   logic [31:0]          inst;
   logic [31:0]          inst_pc;
   logic                 dec_valid;
   logic                 dec_ready;
   logic [31:0]          dec_pc;
   logic [31:0]          dec_inst;
   logic [OP_TYPE_W-1:0] op_type;
   logic [4:0]           rs1_idx;
   logic [4:0]           rs2_idx;
   logic [4:0]           rd_idx;
   logic [31:0]          imme;
   logic                 rd_we;
   logic                 dec_is_shift;
   logic                 dec_illegal;
   logic [CNT_W-1:0]     shift_cnt;

   modport master (
      output inst_valid, inst, inst_pc, dec_ready,
      input  inst_ready, dec_valid, dec_pc, dec_inst, op_type, rs1_idx, rs2_idx,
             rd_idx, imme, rd_we, dec_is_shift, dec_illegal, shift_cnt
   );

   modport slave (
      input  inst_valid, inst, inst_pc, dec_ready,
      output inst_ready, dec_valid, dec_pc, dec_inst, op_type, rs1_idx, rs2_idx,
             rd_idx, imme, rd_we, dec_is_shift, dec_illegal, shift_cnt
   );
endinterface

// File: rtl/core_skid_buf2.sv
// Generic 2-entry valid/ready FIFO buffer with flush. Output data reads
// zero while empty so downstream never sees stale entries.
module core_skid_buf2 #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   localparam logic [1:0] FULL = 2'(DEPTH);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         head_q, head_d;
   logic         tail_q, tail_d;
   logic [1:0]   count_q, count_d;
   logic         push, pop;

   // Handshake, pointer and occupancy update; flush wins over push and pop.
   always_comb begin
      in_ready  = (count_q != FULL);
      out_valid = (count_q != 2'd0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      out_data  = out_valid ? mem_q[head_q] : '0;
      mem_d     = mem_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (flush) begin
         head_d  = 1'b0;
         tail_d  = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push) begin
            mem_d[tail_q] = in_data;
            tail_d        = ~tail_q;
         end
         if (pop) begin
            head_d = ~head_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state: reset empties the buffer immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage; validity is tracked by count, so no reset is needed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/core_idu_shift_dec.sv
// Registered RV32I shift-class decode stage: decodes the incoming word,
// buffers it in a 2-entry FIFO and presents the head entry to the EXU.
module core_idu_shift_dec
   import core_idu_shift_dec_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   core_idu_shift_dec_if.slave  io
);
   dec_pkt_t         in_pkt;
   dec_pkt_t         head_pkt;
   logic [DEC_PKT_W-1:0] head_bits;
   logic             dec_valid;
   logic             dec_fire;
   logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;

   // Decode the word currently offered by the IFU.
   always_comb begin
      in_pkt = shift_decode(io.inst, io.inst_pc);
   end

   core_skid_buf2 #(
      .W     (DEC_PKT_W),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (io.inst_valid),
      .in_ready  (io.inst_ready),
      .in_data   (in_pkt),
      .out_valid (dec_valid),
      .out_ready (io.dec_ready),
      .out_data  (head_bits)
   );

   assign head_pkt = dec_pkt_t'(head_bits);
   assign dec_fire = dec_valid & io.dec_ready;

   // Count legal shifts handed to the EXU, saturating; flush cycles do not count.
   always_comb begin
      shift_cnt_d = shift_cnt_q;
      if (!flush && dec_fire && head_pkt.is_shift && (shift_cnt_q != '1)) begin
         shift_cnt_d = shift_cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_cnt_q <= '0;
      end else begin
         shift_cnt_q <= shift_cnt_d;
      end
   end

   assign io.dec_valid    = dec_valid;
   assign io.dec_pc       = head_pkt.pc;
   assign io.dec_inst     = head_pkt.inst;
   assign io.op_type      = head_pkt.op_type;
   assign io.rs1_idx      = head_pkt.rs1_idx;
   assign io.rs2_idx      = head_pkt.rs2_idx;
   assign io.rd_idx       = head_pkt.rd_idx;
   assign io.imme         = head_pkt.imme;
   assign io.rd_we        = head_pkt.rd_we;
   assign io.dec_is_shift = head_pkt.is_shift;
   assign io.dec_illegal  = head_pkt.illegal;
   assign io.shift_cnt    = shift_cnt_q;

endmodule

// File: tb/tb_core_idu_shift_dec.sv
// Bench for core_idu_shift_dec: table of decode vectors driven through a
// scoreboard, plus hand sequences for backpressure, flush and async reset.
module tb_core_idu_shift_dec;
   import core_idu_shift_dec_pkg::*;

   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [5:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imme;
      logic        rd_we;
      logic        is_shift;
      logic        illegal;
   } exp_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [5:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imme;
      logic        rd_we;
      logic        is_shift;
      logic        illegal;
   } vec_t;

   logic clk;
   logic rst_n;
   logic flush;

   core_idu_shift_dec_if #(.CNT_W(CNT_W)) bus ();

   core_idu_shift_dec #(.DEPTH(2), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .io    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests;
   int         fails;
   int         npop;
   exp_t       sb[$];
   exp_t       cur_exp;
   logic [CNT_W-1:0] cnt_exp;
   vec_t       vt[13];
   logic [31:0] pc_next;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.inst     = v.inst;
      bus.inst_pc  = pc_next;
      cur_exp      = '{pc: pc_next, inst: v.inst, op: v.op, rs1: v.rs1, rs2: v.rs2, rd: v.rd,
                       imme: v.imme, rd_we: v.rd_we, is_shift: v.is_shift, illegal: v.illegal};
      pc_next      = pc_next + 32'd4;
   endtask

   // One clock: sample at negedge, update the scoreboard, return at posedge+1.
   task automatic step(output bit acc);
      exp_t act;
      exp_t e;
      @(negedge clk);
      chk("shift_cnt", 128'(bus.shift_cnt), 128'(cnt_exp));
      acc = 1'b0;
      if (flush) begin
         sb.delete();
      end else begin
         if (bus.dec_valid && bus.dec_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 128'(1), 128'(0));
            end else begin
               e = sb.pop_front();
               act = '{pc: bus.dec_pc, inst: bus.dec_inst, op: bus.op_type, rs1: bus.rs1_idx,
                       rs2: bus.rs2_idx, rd: bus.rd_idx, imme: bus.imme, rd_we: bus.rd_we,
                       is_shift: bus.dec_is_shift, illegal: bus.dec_illegal};
               chk("dec_out", 128'(act), 128'(e));
               if (e.is_shift && cnt_exp != CNT_MAX) cnt_exp = cnt_exp + 1'b1;
            end
            npop++;
         end
         if (bus.inst_valid && bus.inst_ready) begin
            sb.push_back(cur_exp);
            acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit a;
      for (int c = 0; c < 20 && sb.size() != 0; c++) step(a);
      chk("drain_empty", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int k;
      int np0;
      int bp[3];

      vt[0]  = '{32'h00331293, OP_TYPE_SLLI, 5'd6,  5'd0, 5'd5,  32'h00000003, 1'b1, 1'b1, 1'b0};
      vt[1]  = '{32'h41F15093, OP_TYPE_SRAI, 5'd2,  5'd0, 5'd1,  32'h0000041F, 1'b1, 1'b1, 1'b0};
      vt[2]  = '{32'h005211B3, OP_TYPE_SLL,  5'd4,  5'd5, 5'd3,  32'h00000000, 1'b1, 1'b1, 1'b0};
      vt[3]  = '{32'h02331293, 6'd0,         5'd6,  5'd0, 5'd5,  32'h00000023, 1'b0, 1'b0, 1'b1};
      vt[4]  = '{32'h00000013, 6'd0,         5'd0,  5'd0, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{32'h009453B3, OP_TYPE_SRL,  5'd8,  5'd9, 5'd7,  32'h00000000, 1'b1, 1'b1, 1'b0};
      vt[6]  = '{32'h40C5D533, OP_TYPE_SRA,  5'd11, 5'd12, 5'd10, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vt[7]  = '{32'h00775693, OP_TYPE_SRLI, 5'd14, 5'd0, 5'd13, 32'h00000007, 1'b1, 1'b1, 1'b0};
      vt[8]  = '{32'h4020D033, OP_TYPE_SRA,  5'd1,  5'd2, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b0};
      vt[9]  = '{32'h003100B3, 6'd0,         5'd2,  5'd3, 5'd1,  32'h00000000, 1'b0, 1'b0, 1'b0};
      vt[10] = '{32'h20015093, 6'd0,         5'd2,  5'd0, 5'd1,  32'h00000200, 1'b0, 1'b0, 1'b1};
      vt[11] = '{32'hFFF00093, 6'd0,         5'd0,  5'd0, 5'd1,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vt[12] = '{32'h025211B3, 6'd0,         5'd4,  5'd5, 5'd3,  32'h00000000, 1'b0, 1'b0, 1'b1};
      bp[0] = 0; bp[1] = 1; bp[2] = 2;

      tests = 0; fails = 0; npop = 0; cnt_exp = '0;
      pc_next = 32'h0000_1000;
      rst_n = 1'b0; flush = 1'b0;
      bus.inst_valid = 1'b0; bus.inst = '0; bus.inst_pc = '0; bus.dec_ready = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dec_valid",  128'(bus.dec_valid), 128'(0));
      chk("rst_inst_ready", 128'(bus.inst_ready), 128'(1));
      chk("rst_shift_cnt",  128'(bus.shift_cnt), 128'(0));
      chk("rst_dec_pc",     128'(bus.dec_pc), 128'(0));
      chk("rst_op_type",    128'(bus.op_type), 128'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // One-cycle latency and counter step for a single slli.
      bus.dec_ready = 1'b1;
      drive(vt[0]);
      bus.inst_valid = 1'b1;
      step(acc);
      bus.inst_valid = 1'b0;
      chk("lat_dec_valid", 128'(bus.dec_valid), 128'(1));
      chk("lat_op_type",   128'(bus.op_type), 128'(OP_TYPE_SLLI));
      chk("lat_imme",      128'(bus.imme), 128'(32'h3));
      step(acc);
      chk("lat_shift_cnt", 128'(bus.shift_cnt), 128'(1));

      // Table of decode vectors streamed back-to-back at full rate.
      for (int i = 0; i < 13; i++) begin
         drive(vt[i]);
         bus.inst_valid = 1'b1;
         step(acc);
         chk("tbl_accept", 128'(acc), 128'(1));
      end
      bus.inst_valid = 1'b0;
      drain();
      chk("idle_dec_pc", 128'(bus.dec_pc), 128'(0));
      chk("idle_imme",   128'(bus.imme), 128'(0));

      // Backpressure: two accepts, third held until the EXU drains.
      bus.dec_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         drive(vt[bp[k]]);
         pc_next = pc_next - ((k < 2) ? 32'd0 : 32'd4);
         bus.inst_valid = 1'b1;
         step(acc);
         if (acc) k++;
         else pc_next = pc_next - 32'd4;
      end
      chk("bp_accepts",    128'(k), 128'(2));
      chk("bp_inst_ready", 128'(bus.inst_ready), 128'(0));
      chk("bp_held_op",    128'(bus.op_type), 128'(OP_TYPE_SLLI));
      chk("bp_held_rd",    128'(bus.rd_idx), 128'(5));
      bus.dec_ready = 1'b1;
      np0 = npop;
      for (int c = 0; c < 3; c++) begin
         step(acc);
         if (acc) begin
            k++;
            bus.inst_valid = 1'b0;
         end
      end
      bus.inst_valid = 1'b0;
      chk("bp_pops",   128'(npop - np0), 128'(3));
      chk("bp_accept3", 128'(k), 128'(3));
      chk("bp_empty",  128'(sb.size()), 128'(0));

      // Async reset with an entry in flight.
      bus.dec_ready = 1'b0;
      drive(vt[1]);
      bus.inst_valid = 1'b1;
      step(acc);
      bus.inst_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dec_valid",  128'(bus.dec_valid), 128'(0));
      chk("arst_inst_ready", 128'(bus.inst_ready), 128'(1));
      chk("arst_shift_cnt",  128'(bus.shift_cnt), 128'(0));
      sb.delete();
      cnt_exp = '0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Flush with a full buffer, a pending push and a pending pop.
      bus.dec_ready = 1'b0;
      drive(vt[0]); bus.inst_valid = 1'b1; step(acc);
      drive(vt[2]); step(acc);
      chk("fl_full", 128'(bus.inst_ready), 128'(0));
      drive(vt[1]);
      flush = 1'b1;
      bus.dec_ready = 1'b1;
      step(acc);
      flush = 1'b0;
      bus.inst_valid = 1'b0;
      chk("fl_dec_valid",  128'(bus.dec_valid), 128'(0));
      chk("fl_inst_ready", 128'(bus.inst_ready), 128'(1));
      chk("fl_shift_cnt",  128'(bus.shift_cnt), 128'(0));
      step(acc);
      chk("fl_no_capture", 128'(bus.dec_valid), 128'(0));

      // Traffic resumes cleanly after the flush.
      drive(vt[7]); bus.inst_valid = 1'b1; step(acc);
      drive(vt[4]); step(acc);
      bus.inst_valid = 1'b0;
      drain();
      chk("post_shift_cnt", 128'(bus.shift_cnt), 128'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
